spi_peripheral: RTL and testbench
=================================

// Module: spi_peripheral
// PURPOSE
//  - SPI (mode 0) write-only slave. Decodes 16-bit frames into the five control
//    registers consumed by pwm_peripheral: output enables, PWM enables, duty cycle.
//  - Sits between the top-level ui_in pins and pwm_peripheral. SCLK, COPI and nCS
//    are asynchronous to clk and are synchronised inside this block.
// PARAMETERS
//  SYNC_STAGES  2   flip-flop stages per synchroniser (>=2)
//  FRAME_BITS   16  bits per valid transaction
//  MAX_ADDR     4   highest writable register address; higher addresses are ignored
// PORTS
//  clk              in   1  system clock
//  rst_n            in   1  asynchronous active-low reset
//  sclk             in   1  SPI clock, async
//  copi             in   1  SPI data in, async, sampled on SCLK rising edge
//  ncs              in   1  SPI chip select, active low, async
//  en_reg_out_7_0   out  8  reg 0x00, output enables out[7:0]
//  en_reg_out_15_8  out  8  reg 0x01, output enables out[15:8]
//  en_reg_pwm_7_0   out  8  reg 0x02, PWM enables out[7:0]
//  en_reg_pwm_15_8  out  8  reg 0x03, PWM enables out[15:8]
//  pwm_duty_cycle   out  8  reg 0x04, duty cycle, 0xFF = 100 %
// BEHAVIOUR
//  - Clock and reset: single clock domain (clk). rst_n is asynchronous and active-low.
//  - Reset state: all outputs 8'h00; shift register 0; bit count 0; FSM IDLE;
//    synchroniser flops reset to sclk=0, copi=0, ncs=1.
//  - Frame format, MSB first: [15] R/W (1 = write), [14:8] address, [7:0] data.
//  - Edge detection: compare the synchronised sclk/ncs with a one-cycle-delayed copy.
//    SCLK high and low phases must each last at least SYNC_STAGES+1 clk periods.
//  - FSM states:
//    - IDLE -> SHIFT on synced ncs falling edge. Clear the shift register and bit count.
//    - SHIFT: on each synced sclk rising edge, shift in synced copi (left shift, LSB in).
//      The bit count increments and saturates at FRAME_BITS+1; saturation marks overflow.
//    - SHIFT -> COMMIT on synced ncs rising edge.
//    - COMMIT, lasting 1 cycle:
//      - Write data[7:0] to the addressed register only if count == FRAME_BITS,
//        R/W == 1 and address <= MAX_ADDR.
//      - Otherwise discard silently: short frame, long frame, read, or bad address.
//      - Then go to IDLE.
//  - Latency: the register updates on the clk edge that ends COMMIT.
//    Measured from the physical nCS rising edge, that is SYNC_STAGES+2 clk cycles.
//  - Simultaneous synced sclk rise and ncs rise in the same cycle: ncs wins; that sclk edge is not shifted.
//  - SCLK edges while ncs is high: ignored.
//  - A glitch where ncs falls again during COMMIT: the current frame commits, then
//    IDLE is re-entered. The next frame starts on the next detected ncs fall.
//  - Reset mid-frame: the frame is lost and all registers return to 0.
//  - Read frames: there is no CIPO. R/W = 0 frames are consumed with no register effect.
//  - Registers hold their value indefinitely between writes. Only one register is
//    written per frame, and the others are untouched.
// STRUCTURE
//  - Shared package spi_regs_pkg:
//    - localparams ADDR_EN_OUT_LO=7'h00, ADDR_EN_OUT_HI=7'h01, ADDR_EN_PWM_LO=7'h02,
//      ADDR_EN_PWM_HI=7'h03, ADDR_DUTY=7'h04.
//    - FRAME_BITS.
//    - FSM state encoding IDLE/SHIFT/COMMIT.
//  - Sub-module sync_edge_detect (params SYNC_STAGES, RESET_VAL):
//    - ports clk, rst_n, d_async, q_sync, rise, fall.
//    - instantiated for sclk (RESET_VAL 0), ncs (RESET_VAL 1), copi (RESET_VAL 0; q_sync only).
//  - Top level: FSM, shift register, bit counter, register file.
// TESTING
//  1. Write frame 16'h80F0 -> en_reg_out_7_0 == 8'hF0 within SYNC_STAGES+2 clk after the ncs rise; all other registers stay 0.
//  2. Write frames 0x01=AA, 0x02=55, 0x03=0F, 0x04=80 -> all four registers hold those values; reg 0x00 is unchanged.
//  3. Read frame 16'h0012, address 0x05 write 16'h8512, and address 0x7F write -> no register changes.
//  4. 15-bit frame and 17-bit frame, each writing 0xFF to 0x04 -> pwm_duty_cycle is unchanged.
//  5. Assert rst_n low after 8 bits of a write to 0x00 -> all registers 0. A full frame after reset release writes correctly.
//  6. SCLK at the minimum legal phase (SYNC_STAGES+1 clk), 10 back-to-back random writes -> a scoreboard matches every register.

Source files
------------

// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI control-register slave: register map,
// frame length and the FSM state encoding.
package spi_regs_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous input, followed by a
// single-cycle rise/fall detector on the synchronised value.
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q_sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus a delayed copy of its output for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_sync = sync_q[SYNC_STAGES-1];
    assign rise   = q_sync & ~prev_q;
    assign fall   = ~q_sync & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only slave. Collects a 16-bit frame {rw, addr[6:0], data[7:0]}
// while ncs is low and, when ncs rises, writes data into one of five control
// registers if the frame was exactly FRAME_BITS long, a write, and in range.
module spi_peripheral
    import spi_regs_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = spi_regs_pkg::FRAME_BITS,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    // Counter must reach FRAME_BITS+1, which is the overflow marker.
    localparam int              CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam logic [6:0]       ADDR_MAX = 7'(MAX_ADDR);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic ncs_sync, ncs_rise, ncs_fall;
    logic copi_sync, copi_rise, copi_fall;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_async(sclk),
        .q_sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_async(ncs),
        .q_sync(ncs_sync), .rise(ncs_rise), .fall(ncs_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d_async(copi),
        .q_sync(copi_sync), .rise(copi_rise), .fall(copi_fall)
    );

    spi_state_t              state;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [CNT_W-1:0]        count_q;

    logic       frame_rw;
    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_ok;

    assign frame_rw   = shift_q[FRAME_BITS-1];
    assign frame_addr = shift_q[FRAME_BITS-2 -: 7];
    assign frame_data = shift_q[7:0];
    assign frame_ok   = (count_q == CNT_FULL) && frame_rw && (frame_addr <= ADDR_MAX);

    // Frame FSM: shift while selected, decide and write the register in COMMIT.
    // An ncs rise takes priority over a coincident sclk rise in SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            shift_q         <= '0;
            count_q         <= '0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        shift_q <= '0;
                        count_q <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ncs_rise) begin
                        state <= ST_COMMIT;
                    end else if (sclk_rise) begin
                        shift_q <= {shift_q[FRAME_BITS-2:0], copi_sync};
                        if (count_q != CNT_SAT) begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (frame_ok) begin
                        case (frame_addr)
                            ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
                            ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
                            ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
                            ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
                            ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
                            default: ;
                        endcase
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: bit-banged SPI frames, a register-map model
// updated at the moment the write must become visible, and a per-cycle
// compare of all five outputs against that model.
module tb_spi_peripheral;

    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 2;
    localparam int MIN_HALF    = SYNC_STAGES + 1;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 0;

    // Expected register contents, indexed by register address.
    logic [7:0] model [0:4];

    spi_peripheral #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BITS(16), .MAX_ADDR(4)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check8("reg00", en_reg_out_7_0,  model[0]);
            check8("reg01", en_reg_out_15_8, model[1]);
            check8("reg02", en_reg_pwm_7_0,  model[2]);
            check8("reg03", en_reg_pwm_15_8, model[3]);
            check8("reg04", pwm_duty_cycle,  model[4]);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
    endtask

    // Send nbits of val (MSB first), half = clk periods per SCLK phase.
    // The model changes exactly LAT clk edges after the ncs rise.
    task automatic send(input logic [31:0] val, input int nbits, input int half);
        logic [15:0] frame;
        ncs  = 1'b0;
        sclk = 1'b0;
        wait_clk(half);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = val[i];
            wait_clk(half);
            sclk = 1'b1;
            wait_clk(half);
            sclk = 1'b0;
        end
        wait_clk(half);
        ncs = 1'b1;
        frame = val[15:0];
        repeat (LAT) @(posedge clk);
        if (nbits == 16 && frame[15] && frame[14:8] <= 7'd4)
            model[frame[10:8]] = frame[7:0];
        #1;
        wait_clk(half);
    endtask

    task automatic write_reg(input int addr, input logic [7:0] data, input int half);
        logic [31:0] v;
        v = {16'h0000, 1'b1, 7'(addr), data};
        send(v, 16, half);
    endtask

    // Watchdog
    initial begin
        #2ms;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: bench did not complete within time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [31:0] v;
        int          nb;
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        clear_model();
        wait_clk(3);
        checking = 1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(3);
        check8("reset_duty", pwm_duty_cycle, 8'h00);

        // 1: single write to 0x00
        send(32'h0000_80F0, 16, $urandom_range(MIN_HALF, 6));
        check8("t1_reg00", en_reg_out_7_0, 8'hF0);
        check8("t1_reg04", pwm_duty_cycle, 8'h00);

        // 2: writes to 0x01..0x04
        write_reg(1, 8'hAA, $urandom_range(MIN_HALF, 6));
        write_reg(2, 8'h55, $urandom_range(MIN_HALF, 6));
        write_reg(3, 8'h0F, $urandom_range(MIN_HALF, 6));
        write_reg(4, 8'h80, $urandom_range(MIN_HALF, 6));
        check8("t2_reg00", en_reg_out_7_0,  8'hF0);
        check8("t2_reg01", en_reg_out_15_8, 8'hAA);
        check8("t2_reg02", en_reg_pwm_7_0,  8'h55);
        check8("t2_reg03", en_reg_pwm_15_8, 8'h0F);
        check8("t2_reg04", pwm_duty_cycle,  8'h80);

        // 3: read frame, address 0x05, address 0x7F
        send(32'h0000_0012, 16, MIN_HALF);
        send(32'h0000_8512, 16, MIN_HALF);
        send(32'h0000_FF12, 16, MIN_HALF);
        check8("t3_reg00", en_reg_out_7_0, 8'hF0);
        check8("t3_reg01", en_reg_out_15_8, 8'hAA);

        // 4: short and long frames writing 0xFF to 0x04
        send(32'h0000_84FF >> 1, 15, MIN_HALF);
        send({15'd0, 16'h84FF, 1'b1}, 17, MIN_HALF);
        check8("t4_duty", pwm_duty_cycle, 8'h80);

        // 5: reset after 8 bits of a write to 0x00
        ncs = 1'b0;
        wait_clk(MIN_HALF);
        v = 32'h0000_8033;
        for (int i = 15; i >= 8; i--) begin
            copi = v[i];
            wait_clk(MIN_HALF);
            sclk = 1'b1;
            wait_clk(MIN_HALF);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        clear_model();
        ncs  = 1'b1;
        copi = 1'b0;
        wait_clk(3);
        check8("t5_reg01", en_reg_out_15_8, 8'h00);
        check8("t5_reg04", pwm_duty_cycle, 8'h00);
        rst_n = 1'b1;
        wait_clk(3);
        send(32'h0000_8033, 16, MIN_HALF);
        check8("t5_reg00", en_reg_out_7_0, 8'h33);

        // 6: back-to-back random writes at minimum SCLK phase
        for (int k = 0; k < 10; k++)
            write_reg($urandom_range(0, 4), 8'($urandom_range(0, 255)), MIN_HALF);

        // Mixed random frames: any rw, any address, length 15..17
        for (int k = 0; k < 10; k++) begin
            v  = $urandom;
            nb = $urandom_range(0, 3) == 0 ? $urandom_range(15, 17) : 16;
            if ($urandom_range(0, 1) == 1) v[10:8] = 3'($urandom_range(0, 4));
            if (nb == 16 && $urandom_range(0, 1) == 1) v[14:11] = 4'h0;
            send(v, nb, $urandom_range(MIN_HALF, 5));
        end

        wait_clk(4);
        checking = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
